id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core, directly upstream of the ALU controller and ALU.
- Captures decoded control (ALUOp, Funct3, Funct7, memory/writeback controls), operands, immediate, PC and register indices from ID, and presents them to EX.
- Contains the load-use hazard detector: it raises a stall request to IF/ID and inserts a bubble into EX. It also honours an external stall and a branch flush.

Parameters:
- DATA_W, 32, width of operands, immediate and PC.
- REG_AW, 5, register-file index width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- id_valid  input  1  ID stage holds a real instruction.
- id_ALUOp  input  2  ALUOp from the main controller.
- id_Funct3  input  3  instr[14:12].
- id_Funct7  input  7  instr[31:25].
- id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch  input  1 each  decoded controls.
- id_RD1, id_RD2, id_Imm, id_PC  input  DATA_W each  operands, immediate, PC.
- id_rs1, id_rs2, id_rd  input  REG_AW each  register indices.
- stall  input  1  external hold request (e.g. data-memory wait).
- flush  input  1  branch taken in EX; squash the instruction entering EX.
- hazard_stall  output  1  combinational; 1 = IF/ID must hold this cycle.
- ex_valid  output  1  EX holds a real instruction.
- ex_* outputs  one per id_* input, same widths  registered copies.

Behaviour:
- Reset (reset=0, asynchronous): every ex_* output and ex_valid go to 0 immediately and stay 0 while reset is low.
  - ex_ALUOp=00 therefore drives the ALU controller to ADD (0010).
  - This is harmless because RegWrite, MemWrite and ex_valid are 0.
- hazard_stall = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Purely combinational; no dependence on stall or flush.
- Per-edge update, highest priority first:
  1. flush=1: load a bubble. ex_valid and all control outputs (ALUOp, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch) = 0; data, index and funct fields = 0. Overrides stall and hazard.
  2. stall=1: hold every register unchanged.
  3. hazard_stall=1: load a bubble as in 1. IF/ID holds, so the dependent instruction is captured one cycle later, once the load's data can be forwarded from MEM.
  4. Otherwise: capture all id_* fields; ex_valid <= id_valid.
- id_valid=0 with no flush, stall or hazard: fields are captured but every control output is forced to 0, so ex_RegWrite, ex_MemWrite and ex_MemRead are never 1 while ex_valid=0.
- Latency: exactly 1 cycle from ID to EX when unobstructed. A load-use pair costs exactly 1 bubble.
- Boundaries:
  - ex_rd=0 never triggers a hazard.
  - rs1==rs2==ex_rd produces a single bubble, not two.
  - A hazard is re-evaluated every cycle. While stall holds a load in EX, hazard_stall may stay 1; no bubble is inserted until stall drops.
  - Reset asserted mid-stall or mid-bubble clears everything. The first edge after release behaves as an unobstructed capture.
- Funct7 and Funct3 pass through unmodified. Decoding is the ALU controller's job.

Test Plan:
- Reset: hold reset=0 with id_* all ones -> every ex_* =0, ex_valid=0, hazard_stall=0. Release, then capture ADD (ALUOp=10, F3=000, F7=0000000, RD1=5, RD2=7, rd=3, RegWrite=1) -> next edge ex_* match, ex_valid=1.
- Load-use: EX holds LW (MemRead=1, rd=4); ID presents ADD with rs1=4 -> hazard_stall=1, next edge ex_valid=0 and controls 0. Following edge captures the ADD with rs1=4.
- x0 guard: EX holds LW rd=0, ID rs1=0 -> hazard_stall=0 and the ID instruction is captured normally.
- Stall hold: stall=1 for 3 cycles while ID changes (SUB F7=0100000, then XOR F3=100) -> ex_* frozen at the prior SUB values. Capture resumes on the first edge with stall=0.
- Flush priority: flush=1 and stall=1 together while EX holds BEQ (ALUOp=01, F3=000) -> next edge bubble: ex_valid=0, ex_ALUOp=00, ex_Branch=0.
- Async reset mid-operation: assert reset between edges while ex_RegWrite=1 -> ex_RegWrite drops to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Holds the decoded instruction presented to EX. Can bubble the EX slot on a
// branch flush or a load-use dependency, and can freeze on an external stall.
module id_ex_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [1:0]        id_ALUOp,
   input  logic [2:0]        id_Funct3,
   input  logic [6:0]        id_Funct7,
   input  logic              id_ALUSrc,
   input  logic              id_MemtoReg,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_Branch,
   input  logic [DATA_W-1:0] id_RD1,
   input  logic [DATA_W-1:0] id_RD2,
   input  logic [DATA_W-1:0] id_Imm,
   input  logic [DATA_W-1:0] id_PC,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              stall,
   input  logic              flush,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [1:0]        ex_ALUOp,
   output logic [2:0]        ex_Funct3,
   output logic [6:0]        ex_Funct7,
   output logic              ex_ALUSrc,
   output logic              ex_MemtoReg,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_Branch,
   output logic [DATA_W-1:0] ex_RD1,
   output logic [DATA_W-1:0] ex_RD2,
   output logic [DATA_W-1:0] ex_Imm,
   output logic [DATA_W-1:0] ex_PC,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd
);

   logic              valid_q,    valid_d;
   logic [1:0]        alu_op_q,   alu_op_d;
   logic [2:0]        funct3_q,   funct3_d;
   logic [6:0]        funct7_q,   funct7_d;
   logic              alu_src_q,  alu_src_d;
   logic              mem2reg_q,  mem2reg_d;
   logic              reg_wr_q,   reg_wr_d;
   logic              mem_rd_q,   mem_rd_d;
   logic              mem_wr_q,   mem_wr_d;
   logic              branch_q,   branch_d;
   logic [DATA_W-1:0] rd1_q,      rd1_d;
   logic [DATA_W-1:0] rd2_q,      rd2_d;
   logic [DATA_W-1:0] imm_q,      imm_d;
   logic [DATA_W-1:0] pc_q,       pc_d;
   logic [REG_AW-1:0] rs1_q,      rs1_d;
   logic [REG_AW-1:0] rs2_q,      rs2_d;
   logic [REG_AW-1:0] rd_q,       rd_d;

   logic load_bubble;
   logic load_capture;
   logic ctrl_en;

   // Load in EX whose destination is read by the instruction in ID; x0 never counts.
   always_comb begin
      hazard_stall = valid_q & mem_rd_q & (rd_q != '0) & id_valid &
                     ((rd_q == id_rs1) | (rd_q == id_rs2));
   end

   // Next-state selection: flush > stall (hold) > hazard bubble > capture.
   always_comb begin
      load_bubble  = flush | (~stall & hazard_stall);
      load_capture = ~flush & ~stall & ~hazard_stall;
      // Controls of a non-valid ID slot are dropped so EX can never write state.
      ctrl_en      = id_valid;

      valid_d   = valid_q;
      alu_op_d  = alu_op_q;
      funct3_d  = funct3_q;
      funct7_d  = funct7_q;
      alu_src_d = alu_src_q;
      mem2reg_d = mem2reg_q;
      reg_wr_d  = reg_wr_q;
      mem_rd_d  = mem_rd_q;
      mem_wr_d  = mem_wr_q;
      branch_d  = branch_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;

      if (load_bubble) begin
         valid_d   = 1'b0;
         alu_op_d  = '0;
         funct3_d  = '0;
         funct7_d  = '0;
         alu_src_d = 1'b0;
         mem2reg_d = 1'b0;
         reg_wr_d  = 1'b0;
         mem_rd_d  = 1'b0;
         mem_wr_d  = 1'b0;
         branch_d  = 1'b0;
         rd1_d     = '0;
         rd2_d     = '0;
         imm_d     = '0;
         pc_d      = '0;
         rs1_d     = '0;
         rs2_d     = '0;
         rd_d      = '0;
      end else if (load_capture) begin
         valid_d   = id_valid;
         alu_op_d  = ctrl_en ? id_ALUOp : 2'b00;
         funct3_d  = id_Funct3;
         funct7_d  = id_Funct7;
         alu_src_d = ctrl_en & id_ALUSrc;
         mem2reg_d = ctrl_en & id_MemtoReg;
         reg_wr_d  = ctrl_en & id_RegWrite;
         mem_rd_d  = ctrl_en & id_MemRead;
         mem_wr_d  = ctrl_en & id_MemWrite;
         branch_d  = ctrl_en & id_Branch;
         rd1_d     = id_RD1;
         rd2_d     = id_RD2;
         imm_d     = id_Imm;
         pc_d      = id_PC;
         rs1_d     = id_rs1;
         rs2_d     = id_rs2;
         rd_d      = id_rd;
      end
   end

   // Pipeline state; asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         alu_op_q  <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         alu_src_q <= 1'b0;
         mem2reg_q <= 1'b0;
         reg_wr_q  <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         branch_q  <= 1'b0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
      end else begin
         valid_q   <= valid_d;
         alu_op_q  <= alu_op_d;
         funct3_q  <= funct3_d;
         funct7_q  <= funct7_d;
         alu_src_q <= alu_src_d;
         mem2reg_q <= mem2reg_d;
         reg_wr_q  <= reg_wr_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
         branch_q  <= branch_d;
         rd1_q     <= rd1_d;
         rd2_q     <= rd2_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         rd_q      <= rd_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_ALUOp    = alu_op_q;
   assign ex_Funct3   = funct3_q;
   assign ex_Funct7   = funct7_q;
   assign ex_ALUSrc   = alu_src_q;
   assign ex_MemtoReg = mem2reg_q;
   assign ex_RegWrite = reg_wr_q;
   assign ex_MemRead  = mem_rd_q;
   assign ex_MemWrite = mem_wr_q;
   assign ex_Branch   = branch_q;
   assign ex_RD1      = rd1_q;
   assign ex_RD2      = rd2_q;
   assign ex_Imm      = imm_q;
   assign ex_PC       = pc_q;
   assign ex_rs1      = rs1_q;
   assign ex_rs2      = rs2_q;
   assign ex_rd       = rd_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, capture, load-use bubbles, x0 guard,
// stall hold, flush priority and asynchronous reset.
module tb_id_ex_pipe_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [1:0]  id_ALUOp;
   logic [2:0]  id_Funct3;
   logic [6:0]  id_Funct7;
   logic        id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch;
   logic [31:0] id_RD1, id_RD2, id_Imm, id_PC;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        stall, flush;
   logic        hazard_stall, ex_valid;
   logic [1:0]  ex_ALUOp;
   logic [2:0]  ex_Funct3;
   logic [6:0]  ex_Funct7;
   logic        ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch;
   logic [31:0] ex_RD1, ex_RD2, ex_Imm, ex_PC;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;

   int checks = 0;
   int passed = 0;

   id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_ALUOp(id_ALUOp), .id_Funct3(id_Funct3), .id_Funct7(id_Funct7),
      .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
      .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch),
      .id_RD1(id_RD1), .id_RD2(id_RD2), .id_Imm(id_Imm), .id_PC(id_PC),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .stall(stall), .flush(flush), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
      .ex_ALUOp(ex_ALUOp), .ex_Funct3(ex_Funct3), .ex_Funct7(ex_Funct7),
      .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
      .ex_RD1(ex_RD1), .ex_RD2(ex_RD2), .ex_Imm(ex_Imm), .ex_PC(ex_PC),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
   );

   // Clock: rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic id_nop();
      id_valid = 0; id_ALUOp = 0; id_Funct3 = 0; id_Funct7 = 0;
      id_ALUSrc = 0; id_MemtoReg = 0; id_RegWrite = 0; id_MemRead = 0;
      id_MemWrite = 0; id_Branch = 0;
      id_RD1 = 0; id_RD2 = 0; id_Imm = 0; id_PC = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0;
   endtask

   task automatic id_alu(input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
      id_nop();
      id_valid = 1; id_ALUOp = 2'b10; id_Funct3 = f3; id_Funct7 = f7; id_RegWrite = 1;
      id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_RD1 = a; id_RD2 = b; id_PC = pc;
   endtask

   task automatic id_lw(input logic [4:0] rs1, input logic [4:0] rd);
      id_nop();
      id_valid = 1; id_ALUSrc = 1; id_MemtoReg = 1; id_RegWrite = 1; id_MemRead = 1;
      id_Funct3 = 3'b010; id_rs1 = rs1; id_rd = rd; id_RD1 = 32'h1000; id_Imm = 32'h8;
   endtask

   initial begin
      // Reset held with every ID input at all ones.
      reset = 0; stall = 0; flush = 0;
      id_valid = 1; id_ALUOp = '1; id_Funct3 = '1; id_Funct7 = '1;
      id_ALUSrc = 1; id_MemtoReg = 1; id_RegWrite = 1; id_MemRead = 1;
      id_MemWrite = 1; id_Branch = 1;
      id_RD1 = '1; id_RD2 = '1; id_Imm = '1; id_PC = '1;
      id_rs1 = '1; id_rs2 = '1; id_rd = '1;
      tick(); tick();
      chk("rst_valid", ex_valid, 0);
      chk("rst_aluop", ex_ALUOp, 0);
      chk("rst_regwrite", ex_RegWrite, 0);
      chk("rst_memread", ex_MemRead, 0);
      chk("rst_funct7", ex_Funct7, 0);
      chk("rst_rd1", ex_RD1, 0);
      chk("rst_pc", ex_PC, 0);
      chk("rst_rd", ex_rd, 0);
      chk("rst_hazard", hazard_stall, 0);

      // Release and capture ADD x3, x1, x2.
      reset = 1;
      id_alu(3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h100);
      tick();
      chk("add_valid", ex_valid, 1);
      chk("add_aluop", ex_ALUOp, 2'b10);
      chk("add_f3", ex_Funct3, 0);
      chk("add_f7", ex_Funct7, 0);
      chk("add_rd1", ex_RD1, 5);
      chk("add_rd2", ex_RD2, 7);
      chk("add_rd", ex_rd, 3);
      chk("add_regwrite", ex_RegWrite, 1);
      chk("add_pc", ex_PC, 32'h100);

      // Load-use: LW x4 then ADD reading x4.
      id_lw(5'd2, 5'd4);
      #1 chk("lw_no_hazard", hazard_stall, 0);
      tick();
      chk("lw_memread", ex_MemRead, 1);
      chk("lw_rd", ex_rd, 4);
      id_alu(3'b000, 7'h00, 5'd4, 5'd5, 5'd6, 32'hAA, 32'hBB, 32'h108);
      #1 chk("lu_hazard", hazard_stall, 1);
      tick();
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_bubble_regwrite", ex_RegWrite, 0);
      chk("lu_bubble_memread", ex_MemRead, 0);
      chk("lu_bubble_aluop", ex_ALUOp, 0);
      chk("lu_bubble_rd1", ex_RD1, 0);
      chk("lu_after_hazard", hazard_stall, 0);
      tick();
      chk("lu_cap_valid", ex_valid, 1);
      chk("lu_cap_rs1", ex_rs1, 4);
      chk("lu_cap_rd1", ex_RD1, 32'hAA);
      chk("lu_cap_rd", ex_rd, 6);

      // rs1 == rs2 == load rd: exactly one bubble.
      id_lw(5'd1, 5'd7);
      tick();
      id_alu(3'b111, 7'h00, 5'd7, 5'd7, 5'd8, 32'h3, 32'h3, 32'h110);
      #1 chk("dual_hazard", hazard_stall, 1);
      tick();
      chk("dual_bubble", ex_valid, 0);
      chk("dual_hazard_clr", hazard_stall, 0);
      tick();
      chk("dual_cap_valid", ex_valid, 1);
      chk("dual_cap_rd", ex_rd, 8);

      // x0 guard: LW to x0 never blocks a reader of x0.
      id_lw(5'd1, 5'd0);
      tick();
      id_alu(3'b000, 7'h00, 5'd0, 5'd0, 5'd9, 32'h11, 32'h0, 32'h118);
      #1 chk("x0_hazard", hazard_stall, 0);
      tick();
      chk("x0_cap_valid", ex_valid, 1);
      chk("x0_cap_rd", ex_rd, 9);
      chk("x0_cap_rd1", ex_RD1, 32'h11);

      // Non-valid ID slot: fields captured, controls dropped.
      id_nop();
      id_RegWrite = 1; id_MemWrite = 1; id_MemRead = 1; id_Branch = 1; id_ALUOp = 2'b10;
      id_RD1 = 32'h55; id_Funct3 = 3'd5;
      tick();
      chk("inv_valid", ex_valid, 0);
      chk("inv_regwrite", ex_RegWrite, 0);
      chk("inv_memwrite", ex_MemWrite, 0);
      chk("inv_memread", ex_MemRead, 0);
      chk("inv_aluop", ex_ALUOp, 0);
      chk("inv_rd1", ex_RD1, 32'h55);
      chk("inv_f3", ex_Funct3, 5);

      // Stall hold: SUB in EX frozen while ID moves on.
      id_alu(3'b000, 7'h20, 5'd1, 5'd2, 5'd10, 32'h9, 32'h4, 32'h120);
      tick();
      chk("sub_f7", ex_Funct7, 7'h20);
      stall = 1;
      id_alu(3'b100, 7'h00, 5'd3, 5'd4, 5'd11, 32'h1, 32'h2, 32'h124);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("hold_f7_%0d", i), ex_Funct7, 7'h20);
         chk($sformatf("hold_rd_%0d", i), ex_rd, 10);
         chk($sformatf("hold_f3_%0d", i), ex_Funct3, 0);
      end
      stall = 0;
      tick();
      chk("resume_f3", ex_Funct3, 3'b100);
      chk("resume_rd", ex_rd, 11);

      // Hazard under stall: load held in EX, no bubble until stall drops.
      id_lw(5'd1, 5'd12);
      tick();
      stall = 1;
      id_alu(3'b000, 7'h00, 5'd1, 5'd12, 5'd13, 32'h7, 32'h8, 32'h130);
      #1 chk("stallhz_hazard", hazard_stall, 1);
      tick();
      chk("stallhz_valid", ex_valid, 1);
      chk("stallhz_memread", ex_MemRead, 1);
      chk("stallhz_rd", ex_rd, 12);
      chk("stallhz_still", hazard_stall, 1);
      stall = 0;
      tick();
      chk("stallhz_bubble", ex_valid, 0);
      tick();
      chk("stallhz_cap_rs2", ex_rs2, 12);
      chk("stallhz_cap_valid", ex_valid, 1);

      // Flush beats stall while BEQ sits in EX.
      id_nop();
      id_valid = 1; id_ALUOp = 2'b01; id_Branch = 1; id_rs1 = 1; id_rs2 = 2; id_RD1 = 32'h33;
      tick();
      chk("beq_branch", ex_Branch, 1);
      chk("beq_aluop", ex_ALUOp, 2'b01);
      flush = 1; stall = 1;
      tick();
      chk("flush_valid", ex_valid, 0);
      chk("flush_aluop", ex_ALUOp, 0);
      chk("flush_branch", ex_Branch, 0);
      chk("flush_rd1", ex_RD1, 0);
      flush = 0; stall = 0;

      // Asynchronous reset between edges, with stall active.
      id_alu(3'b000, 7'h00, 5'd1, 5'd2, 5'd14, 32'h1, 32'h1, 32'h140);
      tick();
      chk("pre_areset_regwrite", ex_RegWrite, 1);
      stall = 1;
      #2 reset = 0;
      #1;
      chk("areset_regwrite", ex_RegWrite, 0);
      chk("areset_valid", ex_valid, 0);
      chk("areset_rd", ex_rd, 0);
      tick();
      reset = 1; stall = 0;
      id_alu(3'b001, 7'h00, 5'd2, 5'd3, 5'd13, 32'h2, 32'h3, 32'h150);
      tick();
      chk("post_reset_valid", ex_valid, 1);
      chk("post_reset_rd", ex_rd, 13);
      chk("post_reset_f3", ex_Funct3, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
